// File: rtl/ro_puf_sampler.sv
// ro_puf_sampler: ring-oscillator PUF controller that counts and compares edges of challenge-selected oscillator pairs.
// Define PUF_MAJORITY_VOTE_EN to measure every bit three times and keep the majority result.
module ro_puf_sampler #(
    parameter int N_RO      = 16,
    parameter int SEL_W     = 4,
    parameter int CNT_W     = 16,
    parameter int WINDOW    = 1024,
    parameter int SETTLE    = 8,
    parameter int RESP_BITS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [RESP_BITS*2*SEL_W-1:0] challenge,
    input  logic [N_RO-1:0]              ro_in,
    output logic [N_RO-1:0]              ro_en,
    output logic                         busy,
    output logic                         done,
    output logic [RESP_BITS-1:0]         response,
    output logic                         error
);
    localparam int TW = $clog2(WINDOW > SETTLE ? WINDOW : SETTLE);
    localparam int BW = RESP_BITS > 1 ? $clog2(RESP_BITS) : 1;
    localparam int NS = 2 ** SEL_W;

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_COUNT, S_COMPARE, S_DONE} state_t;

    state_t                            state, state_n;
    logic [RESP_BITS-1:0][2*SEL_W-1:0] chal_q;
    logic [BW-1:0]                     bit_idx;
    logic [TW-1:0]                     tmr;
    logic [CNT_W-1:0]                  cnt_a, cnt_b;
    logic [N_RO-1:0]                   sync1, sync2, prev, pair_en;
    logic [NS-1:0]                     cur_w, prv_w;
    logic [SEL_W-1:0]                  sel_a, sel_b;
    logic                              valid, edge_a, edge_b, cmp, tie, tmr_end, last_pass, last_bit;
`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0]                        pass_q, votes;
    assign last_pass = pass_q == 2'd2;
`else
    assign last_pass = 1'b1;
`endif

    assign sel_a    = chal_q[bit_idx][SEL_W-1:0];
    assign sel_b    = chal_q[bit_idx][2*SEL_W-1:SEL_W];
    assign valid    = sel_a != sel_b && 32'(sel_a) < N_RO && 32'(sel_b) < N_RO;
    assign pair_en  = (N_RO'(1) << sel_a) | (N_RO'(1) << sel_b);
    assign edge_a   = valid & cur_w[sel_a] & ~prv_w[sel_a];
    assign edge_b   = valid & cur_w[sel_b] & ~prv_w[sel_b];
    assign cmp      = valid && cnt_a > cnt_b;
    assign tie      = cnt_a == cnt_b;
    assign tmr_end  = state == S_SETTLE ? tmr == TW'(SETTLE - 1) : tmr == TW'(WINDOW - 1);
    assign last_bit = last_pass && bit_idx == BW'(RESP_BITS - 1);

    // Zero-pad so any SEL_W-wide index is in range; out-of-range rings read as idle.
    always_comb begin
        cur_w = '0;
        prv_w = '0;
        cur_w[N_RO-1:0] = sync2;
        prv_w[N_RO-1:0] = prev;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:    state_n = start ? S_SETTLE : S_IDLE;
            S_SETTLE:  state_n = tmr_end ? S_COUNT : S_SETTLE;
            S_COUNT:   state_n = tmr_end ? S_COMPARE : S_COUNT;
            S_COMPARE: state_n = last_bit ? S_DONE : S_SETTLE;
            default:   state_n = S_IDLE;
        endcase
        busy  = state != S_IDLE && state != S_DONE;
        done  = state == S_DONE;
        ro_en = (state == S_SETTLE || state == S_COUNT) ? pair_en : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            chal_q   <= '0;
            bit_idx  <= '0;
            tmr      <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            response <= '0;
            error    <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
            pass_q   <= '0;
            votes    <= '0;
`endif
        end else begin
            sync1 <= ro_in;
            sync2 <= sync1;
            prev  <= sync2;
            tmr   <= state_n != state ? '0 : tmr + 1'b1;
            if (state == S_IDLE && start) begin
                chal_q   <= challenge;
                bit_idx  <= '0;
                response <= '0;
                error    <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
                pass_q   <= '0;
                votes    <= '0;
`endif
            end
            if (state == S_COUNT) begin
                cnt_a <= cnt_a + CNT_W'(edge_a && !(&cnt_a));
                cnt_b <= cnt_b + CNT_W'(edge_b && !(&cnt_b));
                error <= error | (edge_a & (&cnt_a)) | (edge_b & (&cnt_b));
            end else if (state != S_COMPARE) begin
                cnt_a <= '0;
                cnt_b <= '0;
            end
            if (state == S_COMPARE) begin
                error   <= error | ~valid | tie;
                bit_idx <= last_pass ? bit_idx + 1'b1 : bit_idx;
`ifdef PUF_MAJORITY_VOTE_EN
                pass_q  <= last_pass ? '0 : pass_q + 1'b1;
                votes   <= last_pass ? '0 : votes + 2'(cmp);
                if (last_pass) response[bit_idx] <= votes + 2'(cmp) >= 2'd2;
`else
                response[bit_idx] <= cmp;
`endif
            end
        end
    end
endmodule

// File: tb/tb_ro_puf_sampler.sv
// tb_ro_puf_sampler: table-driven and randomized bench for ro_puf_sampler, run on a CNT_W=16 and a CNT_W=2 instance in lockstep.
module tb_ro_puf_sampler;
    localparam int N = 4, SW = 2, W = 16, S = 4, RB = 2, CW = RB * 2 * SW;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int P = 3;
`else
    localparam int P = 1;
`endif
    localparam int PASS  = S + W + 1;
    localparam int TOTAL = 1 + RB * P * PASS;

    typedef struct {
        logic [CW-1:0] ch;
        int            p0, p1, p2, p3, ph;
        int            x1, x2, rst_at;
        logic [RB-1:0] er;
        bit            ee;
        bit            use_tbl;
    } vec_t;

    logic          clk = 0, rst = 0, start = 0;
    logic [CW-1:0] challenge = '0;
    logic [N-1:0]  ro_in = '0;
    logic [N-1:0]  en1, en2;
    logic          busy1, busy2, done1, done2, err1, err2;
    logic [RB-1:0] resp1, resp2;
    int            cyc = 0, n_cmp = 0, n_bad = 0;
    int            per[N], ph[N];

    ro_puf_sampler #(.N_RO(N), .SEL_W(SW), .CNT_W(16), .WINDOW(W), .SETTLE(S), .RESP_BITS(RB)) dut (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge), .ro_in(ro_in),
        .ro_en(en1), .busy(busy1), .done(done1), .response(resp1), .error(err1));

    ro_puf_sampler #(.N_RO(N), .SEL_W(SW), .CNT_W(2), .WINDOW(W), .SETTLE(S), .RESP_BITS(RB)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge), .ro_in(ro_in),
        .ro_en(en2), .busy(busy2), .done(done2), .response(resp2), .error(err2));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Ring r as seen at clock edge k: square wave of period per[r], phase ph[r].
    function automatic bit wv(int r, int k);
        return per[r] == 0 ? 1'b0 : ((k + ph[r]) % per[r]) < per[r] / 2;
    endfunction

    // Two synchroniser flops: a rise between edges k-2 and k-1 is counted in the cycle after edge k.
    function automatic int rose(int r, int k);
        return int'(wv(r, k - 1) && !wv(r, k - 2));
    endfunction

    initial forever begin
        @(negedge clk);
        for (int r = 0; r < N; r++) ro_in[r] = wv(r, cyc + 1);
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    task automatic model(input logic [CW-1:0] ch, input int s, input int cmax,
                         output logic [RB-1:0] r, output bit e);
        e = 0;
        r = '0;
        for (int i = 0; i < RB; i++) begin
            int a, b, votes;
            bit ok;
            a = int'(ch[i*2*SW +: SW]);
            b = int'(ch[i*2*SW+SW +: SW]);
            ok = a != b && a < N && b < N;
            votes = 0;
            for (int q = 0; q < P; q++) begin
                int w0, ca, cb;
                w0 = s + (i * P + q) * PASS + S;
                ca = 0;
                cb = 0;
                if (ok) for (int k = w0; k < w0 + W; k++) begin
                    ca += rose(a, k);
                    cb += rose(b, k);
                end
                if (!ok || ca > cmax || cb > cmax) e = 1;
                if (ca > cmax) ca = cmax;
                if (cb > cmax) cb = cmax;
                if (ok && ca == cb) e = 1;
                if (ok && ca > cb) votes++;
            end
            r[i] = 2 * votes > P;
        end
    endtask

    task automatic run(input vec_t v);
        logic [CW-1:0] ch;
        logic [RB-1:0] r1, r2;
        logic [N-1:0]  ee;
        bit            e1, e2;
        int            s, dt, bad;
        per[0] = v.p0; per[1] = v.p1; per[2] = v.p2; per[3] = v.p3;
        for (int r = 0; r < N; r++) ph[r] = v.ph;
        repeat (2) @(negedge clk);
        ch = v.ch;
        challenge = ch;
        start = 1;
        s = cyc + 1;
        @(negedge clk);
        start = 0;
        challenge = CW'($urandom);
        model(ch, s, 65535, r1, e1);
        model(ch, s, 3, r2, e2);
        bad = 0;
        dt = -1;
        for (int t = 0; t <= TOTAL + 3; t++) begin
            int bi, a, b;
            logic eb, ed;
            if (t == v.rst_at) begin
                chk("pre_rst_busy", 32'(busy1), 1);
                chk("pre_rst_sat_err", 32'(err2), 1);
                rst = 1;
                #1;
                chk("rst_out", 32'({busy1, done1, err1, resp1, en1}), 0);
                chk("rst_out_sat", 32'({busy2, done2, err2, resp2, en2}), 0);
                @(negedge clk);
                rst = 0;
                bad = 0;
                for (int i = 0; i < TOTAL; i++) begin
                    @(negedge clk);
                    if (done1 || done2 || busy1 || busy2) bad++;
                end
                chk("rst_no_done", bad, 0);
                return;
            end
            bi = (t / PASS) / P;
            eb = t < TOTAL - 1;
            ed = t == TOTAL - 1;
            ee = '0;
            if (eb && t % PASS < S + W) begin
                a = int'(ch[bi*2*SW +: SW]);
                b = int'(ch[bi*2*SW+SW +: SW]);
                ee = (N'(1) << a) | (N'(1) << b);
            end
            if ({busy1, done1, en1} !== {eb, ed, ee}) bad++;
            if ({busy2, done2, en2} !== {eb, ed, ee}) bad++;
            if (done1 && dt < 0) dt = t;
            if (t == TOTAL - 1) begin
                chk("resp", 32'(resp1), 32'(r1));
                chk("err", 32'(err1), 32'(e1));
                chk("resp_sat", 32'(resp2), 32'(r2));
                chk("err_sat", 32'(err2), 32'(e2));
                if (v.use_tbl) begin
                    chk("tbl_resp", 32'(resp1), 32'(v.er));
                    chk("tbl_err", 32'(err1), 32'(v.ee));
                end
            end
            if (t >= TOTAL - 1 && (resp1 !== r1 || resp2 !== r2)) bad++;
            start = t == v.x1 || t == v.x2;
            @(negedge clk);
        end
        start = 0;
        chk("ctrl_trace", bad, 0);
        chk("latency", dt + 1, TOTAL);
    endtask

    initial begin
        vec_t tbl[8];
        vec_t rv;
        tbl[0] = '{8'h14, 4, 8, 0, 0, 0, -1, -1, -1, 2'b01, 1'b0, 1'b1};
        tbl[1] = '{8'h14, 8, 8, 0, 0, 0, -1, -1, -1, 2'b00, 1'b1, 1'b1};
        tbl[2] = '{8'h4A, 4, 8, 0, 0, 0, -1, -1, -1, 2'b10, 1'b1, 1'b1};
        tbl[3] = '{8'h41, 4, 8, 0, 0, 0, -1, -1, -1, 2'b10, 1'b0, 1'b1};
        tbl[4] = '{8'hEB, 0, 0, 4, 12, 0, -1, -1, -1, 2'b10, 1'b0, 1'b1};
        tbl[5] = '{8'h14, 4, 8, 0, 0, 0, 10, TOTAL - 1, -1, 2'b01, 1'b0, 1'b1};
        tbl[6] = '{8'h14, 4, 8, 0, 0, 0, -1, -1, 20, 2'b00, 1'b0, 1'b0};
        tbl[7] = '{8'h14, 4, 8, 0, 0, 0, -1, -1, -1, 2'b01, 1'b0, 1'b1};
        for (int r = 0; r < N; r++) begin
            per[r] = 0;
            ph[r] = 0;
        end
        rst = 1;
        repeat (2) @(negedge clk);
        chk("reset_state", 32'({busy1, done1, err1, resp1, en1}), 0);
        chk("reset_state_sat", 32'({busy2, done2, err2, resp2, en2}), 0);
        rst = 0;
        for (int i = 0; i < 8; i++) run(tbl[i]);
        for (int i = 0; i < 12; i++) begin
            rv = '{CW'($urandom), int'($urandom_range(4, 12)), int'($urandom_range(4, 12)),
                   int'($urandom_range(4, 12)), int'($urandom_range(4, 12)), int'($urandom_range(0, 11)),
                   -1, -1, -1, 2'b00, 1'b0, 1'b0};
            run(rv);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
